// File: rtl/input_encoder.sv
// Serialises target button/switch levels into strobed 3-bit commands for a downstream decoder.
// Latency: SETUP+HIGH+LOW cycles per command plus one IDLE cycle; no backpressure, targets sampled directly.
module input_encoder #(
    parameter int SETUP_CYCLES = 2,
    parameter int HIGH_CYCLES  = 4,
    parameter int LOW_CYCLES   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] target_buttons,
    input  logic [2:0] target_switches,
    input  logic       sync_req,
    output logic [2:0] number,
    output logic       control,
    output logic       busy,
    output logic       cmd_done,
    output logic       in_sync
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_HIGH  = 2'd2;
    localparam logic [1:0] S_LOW   = 2'd3;

    localparam logic [2:0] CODE_INIT   = 3'd7;
    localparam logic [6:0] SHADOW_INIT = 7'b000_1111;

    logic [1:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] number_q, number_d;
    logic [6:0] shadow_q, shadow_d;
    logic       init_pend_q, init_pend_d;
    logic       control_q;

    // Bit k of the shadow/target vectors corresponds to command code k.
    logic [6:0] tgt;
    assign tgt = {target_switches[0], target_switches[1], target_switches[2],
                  target_buttons[0], target_buttons[1], target_buttons[2], target_buttons[3]};

    logic [6:0] diff;
    logic       found;
    logic [2:0] pick;

    always_comb begin
        diff  = shadow_q ^ tgt;
        found = 1'b0;
        pick  = 3'd0;
        for (int k = 6; k >= 0; k--) begin
            if (diff[k]) begin
                found = 1'b1;
                pick  = 3'(k);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        number_d    = number_q;
        shadow_d    = shadow_q;
        init_pend_d = init_pend_q | sync_req;
        case (state_q)
            S_IDLE: begin
                if (init_pend_q) begin
                    number_d = CODE_INIT;
                    state_d  = S_SETUP;
                    cnt_d    = 8'(SETUP_CYCLES - 1);
                end else if (found) begin
                    number_d = pick;
                    state_d  = S_SETUP;
                    cnt_d    = 8'(SETUP_CYCLES - 1);
                end
            end
            S_SETUP: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_HIGH;
                    cnt_d   = 8'(HIGH_CYCLES - 1);
                    // The shadow reflects the decoder as soon as the strobe rises.
                    if (number_q == CODE_INIT) begin
                        shadow_d    = SHADOW_INIT;
                        init_pend_d = sync_req;
                    end else begin
                        shadow_d = shadow_q ^ (7'b1 << number_q);
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_HIGH: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_LOW;
                    cnt_d   = 8'(LOW_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            number_q    <= CODE_INIT;
            shadow_q    <= SHADOW_INIT;
            init_pend_q <= 1'b1;
            control_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            number_q    <= number_d;
            shadow_q    <= shadow_d;
            init_pend_q <= init_pend_d;
            control_q   <= (state_d == S_HIGH);
        end
    end

    assign number   = number_q;
    assign control  = control_q;
    assign busy     = (state_q != S_IDLE);
    assign cmd_done = (state_q == S_LOW) && (cnt_q == 8'd0);
    assign in_sync  = (state_q == S_IDLE) && !init_pend_q && (shadow_q == tgt);

endmodule

// File: doc/input_encoder.md
INPUT_ENCODER -- requirements
Module: input_encoder

Interface
REQ-001 SETUP_CYCLES, 2: cycles the new number is held with control low before the rising edge; legal range 1..255.
REQ-002 HIGH_CYCLES, 4: cycles control is held high; legal range 1..255.
REQ-003 LOW_CYCLES, 4: cycles control is held low after the falling edge, number held; legal range 1..255.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 clock  in  1  rising-edge system clock.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 target_buttons  in  4  desired levels [3]=button3 .. [0]=button0.
REQ-008 target_switches  in  3  desired levels [2]=switch17, [1]=switch16, [0]=switch15.
REQ-009 sync_req  in  1  one-cycle pulse requesting a forced re-initialisation of the downstream decoder.
REQ-010 number  out  3  command code sent to the decoder.
REQ-011 control  out  1  command strobe; the decoder acts on its rising edge.
REQ-012 busy  out  1  high whenever the FSM is not in IDLE.
REQ-013 cmd_done  out  1  one-cycle pulse on the last LOW cycle of every command.
REQ-014 in_sync  out  1  high in IDLE when no init is pending and the shadow equals the targets.

Function
REQ-015 Code map SHALL be: 0 toggles button3, 1 toggles button2, 2 toggles button1, 3 toggles button0, 4 toggles switch17, 5 toggles switch16, 6 toggles switch15, 7 sets buttons=1111 and switches=000 (INIT).
REQ-016 A 7-bit shadow register SHALL mirror the decoder outputs as they will be after each issued command.
REQ-017 An init_pend flag SHALL be set by reset or sync_req and cleared when an INIT command enters HIGH.
REQ-018 FSM states SHALL be IDLE, SETUP, HIGH and LOW.
REQ-019 From IDLE with init_pend set, the FSM SHALL load number=7 and go to SETUP.
REQ-020 From IDLE with no init pending, the FSM SHALL select the lowest code k whose shadow bit differs from its target, load number=k and go to SETUP; with no mismatch it SHALL stay in IDLE.
REQ-021 INIT SHALL take priority over any toggle.
REQ-022 SETUP SHALL last SETUP_CYCLES cycles with control=0, then move to HIGH.
REQ-023 HIGH SHALL last HIGH_CYCLES cycles with control=1.
REQ-024 On the cycle HIGH is entered, the shadow SHALL update: toggle bit k, or for INIT load buttons 1111 and switches 000.
REQ-025 LOW SHALL last LOW_CYCLES cycles with control=0, assert cmd_done on its final cycle, then return to IDLE.
REQ-026 number SHALL be stable from SETUP entry to LOW exit, so glitch-free setup and hold around the edge are guaranteed.
REQ-027 Command length SHALL be SETUP_CYCLES+HIGH_CYCLES+LOW_CYCLES cycles, and back-to-back commands SHALL have one IDLE cycle between them.
REQ-028 The first rising control edge SHALL occur SETUP_CYCLES+1 cycles after the IDLE cycle that detects work.
REQ-029 Target changes during a command SHALL NOT abort it, and the next selection SHALL use the current targets, so a toggle followed by a reverse toggle is legal.
REQ-030 sync_req while busy SHALL set init_pend; the current command SHALL complete first.
REQ-031 sync_req in the same cycle as reset SHALL have the same result as reset alone.
REQ-032 Targets SHALL be sampled directly, with no internal synchronizers; the driver provides them synchronous to clock.

Reset
REQ-033 Reset SHALL force state=IDLE, control=0, number=3'b111, busy=0, cmd_done=0, in_sync=0, shadow buttons=1111, shadow switches=000, init_pend=1 and all cycle counters=0.
REQ-034 Reset asserted mid-command SHALL drive control=0 on the next edge.
REQ-035 After reset deasserts, the first command issued SHALL be INIT.

Verification (defaults 2/4/4)
REQ-036 Release reset with targets buttons=1111 and switches=000 -> number=7, control high on cycles 4-7 after release, cmd_done on cycle 11, then in_sync=1 with no further commands.
REQ-037 After sync, set target_buttons=1110 -> one code-3 command, one rising edge, then in_sync=1.
REQ-038 After sync, set buttons=0111 and switches=100 together -> code 0 then code 4, 11-cycle spacing between rising edges.
REQ-039 Set button2 target low, then restore it during HIGH -> code 1 completes, a second code-1 command follows, then in_sync=1.
REQ-040 Pulse sync_req during a code-5 command -> code 5 completes, then INIT, then toggles restoring all non-default targets.
REQ-041 Assert reset during HIGH -> control=0 next cycle, number=7; after release the full INIT sequence runs.
